// File: rtl/studio2_keypad.sv
// studio2_keypad
// ---------------------------------------------------------------------------
// Keypad front end for the Studio II core. Decodes MiSTer ps2_key events into
// two 10-key keypad masks, latches the key-select nibble written by the
// CDP1802 with OUT 2, and drives the four active-low CPU external flags.
//
// Key presses are stretched: after a press, a release of any key on the same
// keypad is held off until that keypad's hold counter has run down, so short
// taps stay visible to the CPU's polling loop for at least HOLD_CYCLES cycles.
//
// Configuration macro:
//   KEYPAD2_NUMPAD_EN  defined   -> keypad 2 uses the non-extended numpad
//                      undefined -> keypad 2 uses the QWERTY row Q..P
//
// Parameters:
//   HOLD_CYCLES  minimum cycles a press stays visible (0 = no stretching)
//
// Ports:
//   clk_sys    in   1   system clock, rising edge
//   reset      in   1   synchronous active-high reset
//   ps2_key    in  11   [10] toggle, [9] pressed, [8] extended, [7:0] scan code
//   io_n       in   3   CPU N lines
//   io_out     in   1   CPU OUT strobe, one cycle per OUT
//   cpu_dout   in   8   CPU data during OUT
//   efx_n      in   1   pixie display-status flag, active low
//   ef_n       out  4   EF4..EF1, active low, registered
//   key_sel    out  4   select latch, registered
//   kp1_state  out 10   keypad 1 key-down mask, bit k = digit k
//   kp2_state  out 10   keypad 2 key-down mask, bit k = digit k
//
// Handshake: there is no valid/ready flow control here. A key event is valid
// for exactly one cycle, the cycle in which ps2_key[10] differs from its
// registered copy; a select write is valid in any cycle with io_out=1 and
// io_n=2. Both are always accepted.
// ---------------------------------------------------------------------------
module studio2_keypad #(
    parameter int HOLD_CYCLES = 20000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [2:0]  io_n,
    input  logic        io_out,
    input  logic [7:0]  cpu_dout,
    input  logic        efx_n,
    output logic [3:0]  ef_n,
    output logic [3:0]  key_sel,
    output logic [9:0]  kp1_state,
    output logic [9:0]  kp2_state
);

    // Counter just wide enough for HOLD_CYCLES; at least one bit.
    localparam int CW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic                toggle_q;
    logic [1:0][9:0]     state_q, state_d;
    logic [1:0][9:0]     pend_q,  pend_d;
    logic [1:0][CW-1:0]  cnt_q,   cnt_d;
    logic [1:0]          hit;
    logic [1:0][3:0]     idx;
    logic [1:0][9:0]     onehot;
    logic                new_event;
    logic                pressed;
    logic [15:0]         kp1_wide;
    logic [15:0]         kp2_wide;

    assign new_event = (ps2_key[10] != toggle_q);
    assign pressed   = ps2_key[9];

    // Keypad 1 decode: digit row 1..0 on the main keyboard.
    always_comb begin
        hit[0] = 1'b1;
        idx[0] = 4'd0;
        case (ps2_key[7:0])
            8'h16: idx[0] = 4'd1;
            8'h1E: idx[0] = 4'd2;
            8'h26: idx[0] = 4'd3;
            8'h25: idx[0] = 4'd4;
            8'h2E: idx[0] = 4'd5;
            8'h36: idx[0] = 4'd6;
            8'h3D: idx[0] = 4'd7;
            8'h3E: idx[0] = 4'd8;
            8'h46: idx[0] = 4'd9;
            8'h45: idx[0] = 4'd0;
            default: hit[0] = 1'b0;
        endcase
        // Extended codes never map to a keypad key.
        if (!new_event || ps2_key[8]) hit[0] = 1'b0;
    end

    // Keypad 2 decode.
    always_comb begin
        hit[1] = 1'b1;
        idx[1] = 4'd0;
        case (ps2_key[7:0])
`ifdef KEYPAD2_NUMPAD_EN
            8'h70: idx[1] = 4'd0;
            8'h69: idx[1] = 4'd1;
            8'h72: idx[1] = 4'd2;
            8'h7A: idx[1] = 4'd3;
            8'h6B: idx[1] = 4'd4;
            8'h73: idx[1] = 4'd5;
            8'h74: idx[1] = 4'd6;
            8'h6C: idx[1] = 4'd7;
            8'h75: idx[1] = 4'd8;
            8'h7D: idx[1] = 4'd9;
`else
            8'h15: idx[1] = 4'd1;
            8'h1D: idx[1] = 4'd2;
            8'h24: idx[1] = 4'd3;
            8'h2D: idx[1] = 4'd4;
            8'h2C: idx[1] = 4'd5;
            8'h35: idx[1] = 4'd6;
            8'h3C: idx[1] = 4'd7;
            8'h43: idx[1] = 4'd8;
            8'h44: idx[1] = 4'd9;
            8'h4D: idx[1] = 4'd0;
`endif
            default: hit[1] = 1'b0;
        endcase
        if (!new_event || ps2_key[8]) hit[1] = 1'b0;
    end

    assign onehot[0] = 10'd1 << idx[0];
    assign onehot[1] = 10'd1 << idx[1];

    // Next state per keypad. Expiry is applied first so that a press of a
    // pending key in the expiry cycle re-sets the bit (press wins). A release
    // arriving while the counter is 0 or in its final (1->0) cycle clears the
    // bit directly instead of being queued.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        for (int p = 0; p < 2; p++) begin
            if (cnt_q[p] != '0) begin
                cnt_d[p] = cnt_q[p] - CNT_ONE;
            end
            if (cnt_q[p] == CNT_ONE) begin
                state_d[p] = state_q[p] & ~pend_q[p];
                pend_d[p]  = '0;
            end
            if (hit[p]) begin
                if (pressed) begin
                    state_d[p] = state_d[p] | onehot[p];
                    pend_d[p]  = pend_d[p] & ~onehot[p];
                    cnt_d[p]   = HOLD_LOAD;
                end else if (cnt_q[p] <= CNT_ONE) begin
                    state_d[p] = state_d[p] & ~onehot[p];
                end else begin
                    pend_d[p]  = pend_d[p] | onehot[p];
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        // Loading the live toggle in reset avoids a spurious event afterwards.
        toggle_q <= ps2_key[10];
        if (reset) begin
            state_q <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_sel <= 4'd0;
        end else if (io_out && (io_n == 3'd2)) begin
            key_sel <= cpu_dout[3:0];
        end
    end

    // Zero-extended masks: select values 10..15 read a 0 bit, giving flag=1.
    assign kp1_wide = {6'd0, state_q[0]};
    assign kp2_wide = {6'd0, state_q[1]};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ef_n <= 4'b1111;
        end else begin
            ef_n <= {~kp2_wide[key_sel], ~kp1_wide[key_sel], 1'b1, efx_n};
        end
    end

    assign kp1_state = state_q[0];
    assign kp2_state = state_q[1];

endmodule

// File: tb/tb_studio2_keypad.sv
// Directed bench for studio2_keypad with HOLD_CYCLES=8.
// Expected ef_n values are pushed into exp_q when stimulus is driven and
// popped when the flag output is due; masks and key_sel are compared
// against constants derived from the key maps.
module tb_studio2_keypad;

    localparam int HOLD = 8;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [2:0]  io_n;
    logic        io_out;
    logic [7:0]  cpu_dout;
    logic        efx_n;
    logic [3:0]  ef_n;
    logic [3:0]  key_sel;
    logic [9:0]  kp1_state;
    logic [9:0]  kp2_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];

    logic [7:0] kp1_codes [10];
    logic [7:0] kp2_codes [10];

    studio2_keypad #(.HOLD_CYCLES(HOLD)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .io_n      (io_n),
        .io_out    (io_out),
        .cpu_dout  (cpu_dout),
        .efx_n     (efx_n),
        .ef_n      (ef_n),
        .key_sel   (key_sel),
        .kp1_state (kp1_state),
        .kp2_state (kp2_state)
    );

    // ---------------- clock ----------------
    always #5 clk_sys = ~clk_sys;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic p, input logic e, input logic [7:0] code);
        ps2_key = {~ps2_key[10], p, e, code};
        tick();
    endtask

    task automatic cpu_out(input logic [2:0] n, input logic [7:0] d);
        io_n     = n;
        cpu_dout = d;
        io_out   = 1'b1;
        tick();
        io_out   = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_ef(input logic [3:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check_ef(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s: observed %b expected queued value (queue empty)", tag, ef_n);
        end else begin
            e = exp_q.pop_front();
            check(tag, 16'(ef_n), 16'(e));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        kp1_codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
`ifdef KEYPAD2_NUMPAD_EN
        kp2_codes = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
`else
        kp2_codes = '{8'h4D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
`endif
        reset    = 1'b1;
        ps2_key  = 11'd0;
        io_n     = 3'd0;
        io_out   = 1'b0;
        cpu_dout = 8'd0;
        efx_n    = 1'b1;

        // Reset state
        expect_ef(4'b1111);
        tick();
        tick();
        reset = 1'b0;
        check_ef("reset_ef");
        check("reset_sel", 16'(key_sel), 16'd0);
        check("reset_kp1", 16'(kp1_state), 16'd0);
        check("reset_kp2", 16'(kp2_state), 16'd0);

        // Select latch: N=3 ignored, N=2 takes the low nibble
        cpu_out(3'd3, 8'h07);
        check("sel_n3_ignored", 16'(key_sel), 16'd0);
        cpu_out(3'd2, 8'hA5);
        check("sel_write", 16'(key_sel), 16'd5);

        // Press '5' (2E): mask after 1 cycle, flag after 2
        expect_ef(4'b1111);
        expect_ef(4'b1011);
        send_key(1'b1, 1'b0, 8'h2E);
        check("press5_kp1", 16'(kp1_state), 16'h020);
        check_ef("press5_ef_lat1");
        tick();
        check_ef("press5_ef_lat2");
        check("press5_kp2", 16'(kp2_state), 16'd0);

        // Let the hold expire, then release clears immediately
        repeat (HOLD) tick();
        send_key(1'b0, 1'b0, 8'h2E);
        check("rel5_immediate", 16'(kp1_state), 16'd0);
        expect_ef(4'b1111);
        tick();
        check_ef("rel5_ef");

        // Hold stretching: press '1', release 2 cycles later
        cpu_out(3'd2, 8'h01);
        send_key(1'b1, 1'b0, 8'h16);
        check("hold_press", 16'(kp1_state), 16'h002);
        expect_ef(4'b1011);
        tick();
        check_ef("hold_ef_on");
        send_key(1'b0, 1'b0, 8'h16);
        check("hold_pending", 16'(kp1_state), 16'h002);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_stretch", 16'(kp1_state), 16'h002);
        end
        expect_ef(4'b1011);
        tick();
        check("hold_expire_clear", 16'(kp1_state), 16'd0);
        check_ef("hold_expire_ef");
        expect_ef(4'b1111);
        tick();
        check_ef("hold_ef_off");

        // key_sel=12 with every key down on both keypads
        cpu_out(3'd2, 8'h0C);
        for (int d = 0; d < 10; d++) begin
            expect_ef(4'b1111);
            send_key(1'b1, 1'b0, kp1_codes[d]);
            check_ef("sel12_kp1_press");
        end
        for (int d = 0; d < 10; d++) begin
            expect_ef(4'b1111);
            send_key(1'b1, 1'b0, kp2_codes[d]);
            check_ef("sel12_kp2_press");
        end
        check("all_kp1", 16'(kp1_state), 16'h3FF);
        check("all_kp2", 16'(kp2_state), 16'h3FF);
        expect_ef(4'b1111);
        tick();
        check_ef("sel12_held");
        repeat (HOLD + 1) tick();
        for (int d = 0; d < 10; d++) begin
            send_key(1'b0, 1'b0, kp1_codes[d]);
            send_key(1'b0, 1'b0, kp2_codes[d]);
        end
        check("all_rel_kp1", 16'(kp1_state), 16'd0);
        check("all_rel_kp2", 16'(kp2_state), 16'd0);

        // Extended code ignored; two toggles with identical data
        cpu_out(3'd2, 8'h01);
        send_key(1'b1, 1'b1, 8'h16);
        send_key(1'b1, 1'b1, 8'h16);
        check("ext_kp1", 16'(kp1_state), 16'd0);
        check("ext_kp2", 16'(kp2_state), 16'd0);
        expect_ef(4'b1111);
        tick();
        check_ef("ext_ef");

        // A held toggle level is one event: counter must not keep reloading
        send_key(1'b1, 1'b0, 8'h16);
        repeat (HOLD + 1) tick();
        send_key(1'b0, 1'b0, 8'h16);
        check("single_event", 16'(kp1_state), 16'd0);

        // Keypad 2 map selection
        cpu_out(3'd2, 8'h09);
        send_key(1'b1, 1'b0, 8'h7D);
`ifdef KEYPAD2_NUMPAD_EN
        expect_ef(4'b0111);
`else
        expect_ef(4'b1111);
`endif
        tick();
        check_ef("kp2_numpad_code");
        send_key(1'b1, 1'b0, 8'h44);
        expect_ef(4'b0111);
        tick();
        check_ef("kp2_code44");
        check("kp2_mask", 16'(kp2_state), 16'h200);

        // Reset mid-hold with a pending release
        send_key(1'b1, 1'b0, 8'h16);
        send_key(1'b0, 1'b0, 8'h16);
        check("pre_reset_kp1", 16'(kp1_state), 16'h002);
        reset = 1'b1;
        expect_ef(4'b1111);
        tick();
        reset = 1'b0;
        check_ef("midreset_ef");
        check("midreset_kp1", 16'(kp1_state), 16'd0);
        check("midreset_kp2", 16'(kp2_state), 16'd0);
        check("midreset_sel", 16'(key_sel), 16'd0);
        efx_n = 1'b0;
        expect_ef(4'b1110);
        tick();
        check_ef("efx_low");
        repeat (HOLD + 2) tick();
        check("pending_discarded", 16'(kp1_state), 16'd0);
        efx_n = 1'b1;
        expect_ef(4'b1111);
        tick();
        check_ef("efx_high");

        // Select write and key event in the same cycle
        io_n     = 3'd2;
        cpu_dout = 8'h03;
        io_out   = 1'b1;
        send_key(1'b1, 1'b0, 8'h26);
        io_out   = 1'b0;
        check("same_cycle_sel", 16'(key_sel), 16'd3);
        check("same_cycle_kp1", 16'(kp1_state), 16'h008);
        expect_ef(4'b1011);
        tick();
        check_ef("same_cycle_ef");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/studio2_keypad.md
# studio2_keypad

Keypad front end for the Studio II core. It decodes MiSTer `ps2_key` events into two 10-key keypad matrices. It latches the key-select nibble written by the CDP1802 with `OUT 2`, and drives the four CPU external flags. The block sits between the HPS keyboard input and the `cdp1802` EF inputs, and it replaces the ad-hoc keypad/EF logic in the top level. EF1 passes through from the pixie video `EFx` output.

## Interface
Parameters:
- `HOLD_CYCLES`, default 20000: minimum number of `clk_sys` cycles a press stays visible to the CPU after the press event. 0 disables stretching.

Ports:
- `clk_sys`  in  1  system clock; all logic runs on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_key`  in  11  MiSTer key event: [10] toggle, [9] pressed, [8] extended, [7:0] scan code.
- `io_n`  in  3  CPU N lines.
- `io_out`  in  1  CPU OUT strobe; one cycle per OUT instruction.
- `cpu_dout`  in  8  CPU data driven during OUT.
- `efx_n`  in  1  pixie display-status flag, active low.
- `ef_n`  out  4  CPU EF4..EF1, active low. Registered.
- `key_sel`  out  4  current select latch. Registered.
- `kp1_state`  out  10  keypad 1 key-down mask, bit k = digit k.
- `kp2_state`  out  10  keypad 2 key-down mask, bit k = digit k.

## Operation
- Event detect: a registered copy of `ps2_key[10]` is kept. A new event is flagged when `ps2_key[10]` differs from the registered copy. Exactly one event is processed per toggle.
- Keypad 1 mapping (requires `ps2_key[8]`=0):
  - 16→1, 1E→2, 26→3, 25→4, 2E→5
  - 36→6, 3D→7, 3E→8, 46→9, 45→0
- Keypad 2 mapping: selected by the configuration macro (see below).
- Any other code or extended flag: the event is ignored and no state changes.
- Press event (`ps2_key[9]`=1):
  - Set the key's bit.
  - Clear the key's pending-release bit.
  - Reload that keypad's hold counter to `HOLD_CYCLES`.
- Release event (`ps2_key[9]`=0):
  - If that keypad's hold counter is 0, clear the key's bit now.
  - Otherwise set the key's pending-release bit.
- Hold counters: one per keypad.
  - Decrement by 1 each cycle while nonzero.
  - In the cycle the counter goes 1→0, clear every bit set in the pending mask, and clear the pending mask.
  - Counter width is the minimum needed to hold `HOLD_CYCLES`. It saturates at 0 and never wraps.
- Select latch: when `io_out`=1 and `io_n`=3'd2, `key_sel` ← `cpu_dout[3:0]`. Other N values are ignored.
- Flags:
  - `ef_n[0]` ← `efx_n`.
  - `ef_n[1]` ← 1 (EF2 is not connected).
  - `ef_n[2]` ← ~`kp1_state[key_sel]`.
  - `ef_n[3]` ← ~`kp2_state[key_sel]`.
  - If `key_sel` is 10..15, both `ef_n[2]` and `ef_n[3]` are 1.
- Auto-repeat: repeated make codes while a key is already down reload the hold counter. The key stays down.

## Timing
- Reset values: `ef_n`=4'b1111, `key_sel`=0, both state masks 0, pending masks 0, hold counters 0. The event-detect register loads the current `ps2_key[10]`, so no spurious event occurs after reset.
- Event → state mask: 1 cycle. State mask → `ef_n`: 1 further cycle. Total latency from a `ps2_key` toggle to `ef_n` is 2 cycles.
- Select write → `key_sel`: 1 cycle. `key_sel` → `ef_n`: 1 further cycle.
- Select write and key event in the same cycle: both are applied. `ef_n` two cycles later reflects both.
- Release event in the same cycle as the hold counter reaching 0: the release is applied immediately, not queued.
- Press event in the same cycle as the counter reaching 0 with the same key pending: the press wins. The bit stays set and the counter is reloaded.
- Reset asserted mid-hold: all state is cleared in the next cycle. Pending releases are discarded.

## Configuration
- `KEYPAD2_NUMPAD_EN` defined: keypad 2 maps to the non-extended numeric keypad.
  - 70→0, 69→1, 72→2, 7A→3, 6B→4
  - 73→5, 74→6, 6C→7, 75→8, 7D→9
- `KEYPAD2_NUMPAD_EN` undefined: keypad 2 maps to the QWERTY row.
  - 15(Q)→1, 1D(W)→2, 24(E)→3, 2D(R)→4, 2C(T)→5
  - 35(Y)→6, 3C(U)→7, 43(I)→8, 44(O)→9, 4D(P)→0
  - Numpad codes are ignored.

## Test plan
- Reset, then OUT with `io_n`=2 and data 8'h05, then toggle `ps2_key` with {pressed=1, ext=0, 8'h2E} → `kp1_state`=10'h020. `ef_n[2]`=0 two cycles after the toggle; `ef_n[3]`=1.
- `HOLD_CYCLES`=8: press 8'h16, then release 2 cycles later → bit 1 stays set until the counter expires (8 cycles after the press) and clears that cycle. `ef_n[2]` returns to 1 one cycle later.
- `key_sel`=12 with keys 0–9 held on both keypads → `ef_n[3:2]`=2'b11 throughout.
- Extended code {ext=1, 8'h16} press → no state change and `ef_n` unchanged. A second toggle carrying the same event data produces exactly one event.
- With `KEYPAD2_NUMPAD_EN`: press 8'h7D with `key_sel`=9 → `ef_n[3]`=0. Without the macro: the same stimulus leaves `ef_n[3]`=1, and 8'h44 gives `ef_n[3]`=0.
- Assert `reset` for 1 cycle while keys are held and a release is pending → next cycle `ef_n`=4'b1111, both masks 0, `key_sel`=0. `efx_n` toggling is still mirrored on `ef_n[0]` one cycle later.
